// File: rtl/poly_mult_pkg.sv
// Shared constants and types for the sparse polynomial multiplier.
// DUMMY_EN mirrors the DUMMY_INSERT_EN build option so parameters stay in use in both builds.
package poly_mult_pkg;

  localparam int N_COEF = 8;
  localparam int COEF_W = 16;

`ifdef DUMMY_INSERT_EN
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam bit DUMMY_EN = 1'b0;
`endif

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/poly_mult_sched.sv
// Slot scheduler: orders real and key-driven dummy additions; one slot per cycle, last_slot flags the final one.
// No backpressure: advances on every step; start reloads counters and key (DUMMY_INSERT_EN adds dummies).
module poly_mult_sched
  import poly_mult_pkg::*;
#(
  parameter int N      = N_COEF,
  parameter int WEIGHT = 1,
  parameter int DUMMY  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 step,
`ifdef DUMMY_INSERT_EN
  input  logic [127:0]         key,
  output logic                 is_dummy,
  output logic [$clog2(N)-1:0] dummy_idx,
`endif
  output logic [$clog2(N)-1:0] real_i,
  output logic [7:0]           real_j,
  output logic                 last_slot
);

  localparam int              IDX_W  = $clog2(N);
  localparam int              SLOTS  = WEIGHT * N + (DUMMY_EN ? DUMMY : 0);
  localparam logic [7:0]      REAL_C = 8'(WEIGHT * N);
  localparam logic [8:0]      LAST_C = 9'(SLOTS - 1);

  logic [7:0] r_cnt;
  logic [8:0] slot;

  assign real_i = r_cnt[IDX_W-1:0];
  assign real_j = r_cnt >> IDX_W;

`ifdef DUMMY_INSERT_EN
  localparam logic [7:0] DUMMY_C = 8'(DUMMY);

  logic [7:0]   d_cnt;
  logic [127:0] kreg;

  // Once all real terms are done the remaining slots are necessarily dummies.
  assign is_dummy  = (kreg[0] && (d_cnt < DUMMY_C)) || (r_cnt == REAL_C);
  assign dummy_idx = d_cnt[IDX_W-1:0];
  assign slot      = {1'b0, r_cnt} + {1'b0, d_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      d_cnt <= '0;
      kreg  <= '0;
    end else if (start) begin
      r_cnt <= '0;
      d_cnt <= '0;
      kreg  <= key;
    end else if (step) begin
      if (is_dummy) d_cnt <= d_cnt + 8'd1;
      else          r_cnt <= r_cnt + 8'd1;
      kreg <= {kreg[0], kreg[127:1]};
    end
  end
`else
  assign slot = {1'b0, r_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (step) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`endif

  assign last_slot = step && (slot == LAST_C);

endmodule

// File: rtl/poly_mult.sv
// poly_mult: c = a * s mod (x^N - 1), s sparse (+1 at POS); result WEIGHT*N(+DUMMY) cycles after the load edge.
// No backpressure: load_i is ignored while busy_o; DUMMY_INSERT_EN interleaves key-scheduled dummy additions.
module poly_mult
  import poly_mult_pkg::*;
#(
  parameter int                          N      = N_COEF,
  parameter int                          CW     = COEF_W,
  parameter int                          WEIGHT = 1,
  parameter logic [WEIGHT*$clog2(N)-1:0] POS    = '0,
  parameter int                          DUMMY  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         busy_o
);

  localparam int IDX_W = $clog2(N);

  state_t            state, state_nxt;
  logic              start, step, last_slot;
  logic [IDX_W-1:0]  real_i, tgt_idx, pos_sel;
  logic [7:0]        real_j;
  logic [127:0]      a_q;
  logic [CW-1:0]     acc_q   [N];
  logic [CW-1:0]     acc_nxt [N];
  logic [CW-1:0]     operand, base, sum;
  logic [127:0]      result;

`ifdef DUMMY_INSERT_EN
  logic              is_dummy;
  logic [IDX_W-1:0]  dummy_idx;
  logic [CW-1:0]     dacc_q;
`else
  logic              unused_key;
  assign unused_key = ^key_i;
`endif

  assign step   = (state == RUN);
  assign busy_o = step;

  poly_mult_sched #(
    .N      (N),
    .WEIGHT (WEIGHT),
    .DUMMY  (DUMMY)
  ) u_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step      (step),
`ifdef DUMMY_INSERT_EN
    .key       (key_i),
    .is_dummy  (is_dummy),
    .dummy_idx (dummy_idx),
`endif
    .real_i    (real_i),
    .real_j    (real_j),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (load_i) begin
        start     = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last_slot) state_nxt = IDLE;
    endcase
  end

  // Exponent of the sparse term currently being applied.
  always_comb begin
    pos_sel = '0;
    for (int k = 0; k < WEIGHT; k++) begin
      if (real_j == 8'(k)) pos_sel = POS[k*IDX_W +: IDX_W];
    end
  end

  assign tgt_idx = real_i + pos_sel;

  // Single shared adder for real and dummy slots keeps both on the same path.
  always_comb begin
    operand = a_q[int'(real_i)*CW +: CW];
    base    = acc_q[tgt_idx];
`ifdef DUMMY_INSERT_EN
    if (is_dummy) begin
      operand = a_q[int'(dummy_idx)*CW +: CW];
      base    = dacc_q;
    end
`endif
    sum = base + operand;

    for (int k = 0; k < N; k++) acc_nxt[k] = acc_q[k];
`ifdef DUMMY_INSERT_EN
    if (!is_dummy) acc_nxt[tgt_idx] = sum;
`else
    acc_nxt[tgt_idx] = sum;
`endif

    result = '0;
    for (int k = 0; k < N; k++) result[k*CW +: CW] = acc_nxt[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      data_o <= '0;
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
`ifdef DUMMY_INSERT_EN
      dacc_q <= '0;
`endif
    end else if (start) begin
      a_q <= data_i;
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
`ifdef DUMMY_INSERT_EN
      dacc_q <= '0;
`endif
    end else if (step) begin
      for (int k = 0; k < N; k++) acc_q[k] <= acc_nxt[k];
`ifdef DUMMY_INSERT_EN
      if (is_dummy) dacc_q <= sum;
`endif
      if (last_slot) data_o <= result;
    end
  end

endmodule

// File: tb/tb_poly_mult.sv
// Scoreboard bench for poly_mult: three parameterisations, directed cases then random runs.
`timescale 1ns/1ps
module tb_poly_mult;
  import poly_mult_pkg::*;

  localparam int N = 8;
`ifdef DUMMY_INSERT_EN
  localparam int DUM = 8;
`else
  localparam int DUM = 0;
`endif
  localparam logic [127:0] D_SEQ = 128'h8888_7777_6666_5555_4444_3333_2222_1111;

  typedef struct {
    int           inst;
    logic [127:0] data;
    int           len;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load  [3];
  logic [127:0] key   [3];
  logic [127:0] din   [3];
  logic [127:0] dout  [3];
  logic         busy  [3];

  exp_t         q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           wt [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  poly_mult u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_i(load[0]), .key_i(key[0]),
    .data_i(din[0]), .data_o(dout[0]), .busy_o(busy[0]));

  poly_mult #(.POS(3'd1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_i(load[1]), .key_i(key[1]),
    .data_i(din[1]), .data_o(dout[1]), .busy_o(busy[1]));

  poly_mult #(.WEIGHT(2), .POS(6'b001_000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_i(load[2]), .key_i(key[2]),
    .data_i(din[2]), .data_o(dout[2]), .busy_o(busy[2]));

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: c = a * sum_t x^pos_t over Z_(2^16)[x]/(x^8 - 1).
  function automatic logic [127:0] model(int inst, logic [127:0] a);
    int           pos[$];
    coef_t        c [N];
    logic [127:0] r;
    if (inst == 0)      pos.push_back(0);
    else if (inst == 1) pos.push_back(1);
    else begin
      pos.push_back(0);
      pos.push_back(1);
    end
    for (int k = 0; k < N; k++) c[k] = '0;
    foreach (pos[t])
      for (int i = 0; i < N; i++) c[(i + pos[t]) % N] += coef_t'(a[i*16 +: 16]);
    r = '0;
    for (int k = 0; k < N; k++) r[k*16 +: 16] = c[k];
    return r;
  endfunction

  function automatic int run_len(int inst);
    return wt[inst] * N + DUM;
  endfunction

  task automatic expect_run(int inst, logic [127:0] data);
    exp_t e;
    e.inst = inst;
    e.data = data;
    e.len  = run_len(inst);
    q.push_back(e);
  endtask

  // Called at posedge+1; load_i is held across 'cycles' rising edges.
  task automatic pulse(int inst, logic [127:0] k, logic [127:0] d, int cycles);
    key[inst]  = k;
    din[inst]  = d;
    load[inst] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 load[inst] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d runs still pending, expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: data_o must hold while busy; on busy falling, compare against scoreboard.
  int           blen [3];
  logic         prev [3];
  logic [127:0] held [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        blen[i] = 0;
        prev[i] = 1'b0;
        held[i] = '0;
      end else begin
        if (busy[i]) begin
          blen[i]++;
          check($sformatf("hold%0d", i), dout[i], held[i]);
        end else if (prev[i]) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_run%0d: got a completed run, expected none", i);
          end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("inst%0d", i), 128'(i), 128'(e.inst));
            check($sformatf("data%0d", i), dout[i], e.data);
            check($sformatf("busy_len%0d", i), 128'(blen[i]), 128'(e.len));
            held[i] = e.data;
          end
          blen[i] = 0;
        end
        prev[i] = busy[i];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] k, d;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load[i] = 1'b0;
      key[i]  = '0;
      din[i]  = '0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), 128'(busy[i]), 128'(0));
      check($sformatf("rst_data%0d", i), dout[i], 128'(0));
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity operand with three different keys.
    expect_run(0, D_SEQ);
    pulse(0, 128'hDEADBEEF_12345678_DEADBEEF_12345678, D_SEQ, 2);
    wait_idle();
    expect_run(0, D_SEQ);
    pulse(0, '0, D_SEQ, 2);
    wait_idle();
    expect_run(0, D_SEQ);
    pulse(0, '1, D_SEQ, 2);
    wait_idle();

    // s = x: every coefficient moves up one position, top wraps to 0.
    expect_run(1, 128'h7777_6666_5555_4444_3333_2222_1111_8888);
    pulse(1, 128'hDEADBEEF_12345678_DEADBEEF_12345678, D_SEQ, 2);
    wait_idle();

    // s = 1 + x on all-ones: 0xFFFF + 0xFFFF wraps to 0xFFFE.
    expect_run(2, {8{16'hFFFE}});
    pulse(2, 128'h0F0F_F0F0_1234_5678_9ABC_DEF0_5555_AAAA, '1, 2);
    wait_idle();

    // Held load: a new run can only start on the edge after busy falls.
    for (int e = 0; e < 20; e += run_len(0) + 1) expect_run(0, D_SEQ);
    pulse(0, 128'hCAFE_0000_0000_0000_0000_0000_0000_0001, D_SEQ, 20);
    wait_idle();

    // Asynchronous reset in the middle of a run.
    pulse(0, '1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy[0]), 128'(0));
    check("abort_data", dout[0], 128'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    expect_run(0, model(0, d));
    pulse(0, '1, d, 1);
    wait_idle();

    // Random operands and keys across all parameterisations.
    for (int it = 0; it < 12; it++) begin
      int inst;
      inst = $urandom_range(0, 2);
      k = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      expect_run(inst, model(inst, d));
      pulse(inst, k, d, $urandom_range(1, 3));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    check("queue_empty", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
